// File: rtl/scene_pkg.sv
// Shared types, colours and shape geometry for object_column_gen.
// Rock geometry is always declared here; whether rocks appear is set by OBJECT_ROCK_EN.
package scene_pkg;

  typedef enum logic [1:0] {
    OBJ_NONE  = 2'd0,
    OBJ_BENCH = 2'd1,
    OBJ_TREE  = 2'd2,
    OBJ_ROCK  = 2'd3
  } obj_t;

  typedef enum logic {
    S_GAP = 1'b0,
    S_OBJ = 1'b1
  } state_t;

  localparam int BENCH_W = 10;
  localparam int TREE_W  = 6;
  localparam int ROCK_W  = 4;

  localparam logic [2:0] SKY    = 3'b011;
  localparam logic [2:0] GROUND = 3'b010;
  localparam logic [2:0] WOOD   = 3'b110;
  localparam logic [2:0] TRUNK  = 3'b100;
  localparam logic [2:0] LEAF   = 3'b010;
  localparam logic [2:0] ROCK   = 3'b111;

  // Row offsets are heights above the ground line: 1 is row GROUND_Y-1.
  localparam int SEAT_LO     = 5;
  localparam int SEAT_HI     = 6;
  localparam int LEG_HI      = 4;
  localparam int LEG_COL_L   = 1;
  localparam int LEG_COL_R   = 8;
  localparam int TRUNK_HI    = 10;
  localparam int TRUNK_COL_L = 2;
  localparam int TRUNK_COL_R = 3;
  localparam int CANOPY_LO   = 11;
  localparam int CANOPY_HI   = 20;
  localparam int ROCK_HI     = 3;

  localparam logic [4:0] R_BENCH_LIM = 5'd8;
  localparam logic [4:0] R_TREE_LIM  = 5'd16;

  function automatic logic [4:0] obj_width(input obj_t t);
    logic [4:0] w;
    case (t)
      OBJ_BENCH: w = 5'(BENCH_W);
      OBJ_TREE:  w = 5'(TREE_W);
      OBJ_ROCK:  w = 5'(ROCK_W);
      default:   w = 5'd1;
    endcase
    return w;
  endfunction

  function automatic logic [2:0] shape_colour(input obj_t t, input int col, input int h);
    logic [2:0] c;
    c = SKY;
    case (t)
      OBJ_BENCH: begin
        if (h >= SEAT_LO && h <= SEAT_HI)
          c = WOOD;
        else if (h >= 1 && h <= LEG_HI && (col == LEG_COL_L || col == LEG_COL_R))
          c = WOOD;
      end
      OBJ_TREE: begin
        if (h >= 1 && h <= TRUNK_HI && col >= TRUNK_COL_L && col <= TRUNK_COL_R)
          c = TRUNK;
        else if (h >= CANOPY_LO && h <= CANOPY_HI)
          c = LEAF;
      end
      OBJ_ROCK: begin
        if (h >= 1 && h <= ROCK_HI)
          c = ROCK;
      end
      default: c = SKY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with taps LFSR_W, 22, 2, 1; a zero SEED is replaced by 1.
// The MSB tap guarantees a nonzero state never shifts to all zeros.
module lfsr_gen #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = 32'hABCB4DA5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;
  logic              fb;

  always_comb begin
    fb  = q_q[LFSR_W-1] ^ q_q[21] ^ q_q[1] ^ q_q[0];
    q_d = q_q;
    if (enable)
      q_d = {q_q[LFSR_W-2:0], fb};
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      q_q <= SEED_NZ;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/object_column_gen.sv
// Colour generator for the newly exposed rightmost column of a left-scrolling scene.
// Objects are picked by an LFSR; define OBJECT_ROCK_EN to allow rocks.
module object_column_gen
  import scene_pkg::*;
#(
  parameter int                SCREEN_H = 120,
  parameter int                Y_W      = 7,
  parameter int                GROUND_Y = 80,
  parameter int                COLOUR_W = 3,
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] SEED     = 32'hABCB4DA5,
  parameter int                MIN_GAP  = 4,
  parameter int                INIT_GAP = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic [Y_W-1:0]      y,
  input  logic                last_col,
  input  logic [COLOUR_W-1:0] right_colour,
  output logic [COLOUR_W-1:0] colour,
  output logic [1:0]          obj_type,
  output logic                spawn
);

`ifdef OBJECT_ROCK_EN
  localparam logic [4:0] R_ROCK_LIM = 5'd20;
`endif

  state_t              state_q, state_d;
  logic [4:0]          col_left_q, col_left_d;
  logic [4:0]          obj_col_q, obj_col_d;
  obj_t                obj_type_q, obj_type_d;
  logic                spawn_q, spawn_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic [LFSR_W-1:0]   lfsr_q;
  logic [4:0]          r;
  logic                col_end;
  logic [COLOUR_W-1:0] pix_colour;
  logic [2:0]          shape;
  int                  height;
  obj_t                new_type;
  logic                unused_lfsr_hi;

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .q      (lfsr_q)
  );

  assign r              = lfsr_q[4:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:8];
  assign col_end        = enable && last_col && (y == Y_W'(SCREEN_H - 1));

  always_comb begin
    height = GROUND_Y - int'(y);
    shape  = shape_colour(obj_type_q, int'(obj_col_q), height);
`ifndef OBJECT_ROCK_EN
    // Rock can never be current here; masking lets the rock rows drop out.
    if (obj_type_q == OBJ_ROCK)
      shape = SKY;
`endif
    if (int'(y) >= GROUND_Y)
      pix_colour = COLOUR_W'(GROUND);
    else if (!last_col)
      pix_colour = right_colour;
    else
      pix_colour = COLOUR_W'(shape);
  end

  always_comb begin
    state_d    = state_q;
    col_left_d = col_left_q;
    obj_col_d  = obj_col_q;
    obj_type_d = obj_type_q;
    spawn_d    = 1'b0;
    colour_d   = colour_q;
    new_type   = OBJ_NONE;

    if (enable)
      colour_d = pix_colour;

    if (col_end) begin
      if (col_left_q > 5'd1) begin
        col_left_d = col_left_q - 5'd1;
        obj_col_d  = obj_col_q + 5'd1;
      end else begin
        obj_col_d = 5'd0;
        case (state_q)
          S_GAP: begin
            if (r < R_BENCH_LIM)
              new_type = OBJ_BENCH;
            else if (r < R_TREE_LIM)
              new_type = OBJ_TREE;
`ifdef OBJECT_ROCK_EN
            else if (r < R_ROCK_LIM)
              new_type = OBJ_ROCK;
`endif
            if (new_type != OBJ_NONE) begin
              state_d    = S_OBJ;
              obj_type_d = new_type;
              col_left_d = obj_width(new_type);
              spawn_d    = 1'b1;
            end else begin
              col_left_d = 5'(MIN_GAP);
            end
          end
          S_OBJ: begin
            state_d    = S_GAP;
            obj_type_d = OBJ_NONE;
            col_left_d = 5'(MIN_GAP) + 5'(lfsr_q[7:5]);
          end
          default: begin
            state_d    = S_GAP;
            obj_type_d = OBJ_NONE;
            col_left_d = 5'(MIN_GAP);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_GAP;
      col_left_q <= 5'(INIT_GAP);
      obj_col_q  <= 5'd0;
      obj_type_q <= OBJ_NONE;
      spawn_q    <= 1'b0;
      colour_q   <= COLOUR_W'(SKY);
    end else begin
      state_q    <= state_d;
      col_left_q <= col_left_d;
      obj_col_q  <= obj_col_d;
      obj_type_q <= obj_type_d;
      spawn_q    <= spawn_d;
      colour_q   <= colour_d;
    end
  end

  assign colour   = colour_q;
  assign obj_type = obj_type_q;
  assign spawn    = spawn_q;

endmodule

// File: tb/tb_object_column_gen.sv
// Directed bench for object_column_gen; LFSR phase is steered with filler cycles.
module tb_object_column_gen;

  localparam logic [31:0] SEED = 32'hABCB4DA5;
  localparam int N = 2400;

  logic       clock        = 1'b0;
  logic       resetn       = 1'b0;
  logic       enable       = 1'b0;
  logic [6:0] y            = 7'd0;
  logic       last_col     = 1'b0;
  logic [2:0] right_colour = 3'd0;
  logic [2:0] colour;
  logic [1:0] obj_type;
  logic       spawn;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_lfsr = SEED;

  logic [2:0] g_colour [N];
  logic [1:0] g_type   [N];
  logic       g_spawn  [N];

  always #5 clock = ~clock;

  object_column_gen dut (
    .clock        (clock),
    .resetn       (resetn),
    .enable       (enable),
    .y            (y),
    .last_col     (last_col),
    .right_colour (right_colour),
    .colour       (colour),
    .obj_type     (obj_type),
    .spawn        (spawn)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!resetn) m_lfsr = SEED;
    else if (enable) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic pix(input logic [6:0] yy, input logic lc, input logic [2:0] rc);
    enable = 1'b1; y = yy; last_col = lc; right_colour = rc;
    tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; last_col = 1'b0; y = 7'd0; right_colour = 3'd0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  // Burn filler cycles until r lies in lo..hi, then issue one column end.
  task automatic col_end(input int lo, input int hi, output logic [31:0] pre);
    int n;
    n = 0;
    enable = 1'b1; last_col = 1'b1; y = 7'd0;
    while ((int'(m_lfsr[4:0]) < lo || int'(m_lfsr[4:0]) > hi) && n < 2000) begin
      tick(); n++;
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL col_end_seek: r range %0d..%0d not reached in 2000 cycles", lo, hi);
    end
    pre = m_lfsr;
    y = 7'd119; tick(); y = 7'd0;
  endtask

  task automatic drive_step(input int i);
    enable = 1'b1;
    if (i % 6 == 5) begin
      y = 7'd119; last_col = 1'b1;
    end else begin
      y = 7'((i * 13) % 119); last_col = (i % 3 != 1);
    end
    right_colour = 3'(i);
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; y = 7'd119; last_col = 1'b1; right_colour = 3'b101;
    tick(); tick();
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL reset_colour: got %b want 011", colour); end
    tests++; if (obj_type !== 2'd0) begin fails++; $display("FAIL reset_obj_type: got %0d want 0", obj_type); end
    tests++; if (spawn !== 1'b0) begin fails++; $display("FAIL reset_spawn: got %b want 0", spawn); end
    resetn = 1'b1;
  endtask

  task automatic test_colour_select();
    pix(7'd10, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011 || obj_type !== 2'd0) begin fails++; $display("FAIL sky_y10: colour=%b type=%0d want 011/0", colour, obj_type); end
    pix(7'd85, 1'b1, 3'd0);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL ground_y85: got %b want 010", colour); end
    pix(7'd40, 1'b0, 3'b101);
    tests++; if (colour !== 3'b101) begin fails++; $display("FAIL right_y40: got %b want 101", colour); end
    pix(7'd90, 1'b0, 3'b101);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL ground_over_right: got %b want 010", colour); end
    pix(7'd79, 1'b0, 3'b101);
    tests++; if (colour !== 3'b101) begin fails++; $display("FAIL right_y79: got %b want 101", colour); end
    pix(7'd80, 1'b1, 3'd0);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL ground_y80: got %b want 010", colour); end
    enable = 1'b0; y = 7'd40; last_col = 1'b0; right_colour = 3'b001;
    tick();
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL colour_hold: got %b want 010", colour); end
  endtask

  task automatic test_bench();
    logic [31:0] pre;
    int gap;
    logic bad;
    do_reset();
    repeat (3) col_end(0, 31, pre);
    tests++; if (obj_type !== 2'd0 || spawn !== 1'b0) begin fails++; $display("FAIL init_gap: type=%0d spawn=%b want 0/0", obj_type, spawn); end
    col_end(3, 3, pre);
    tests++; if (spawn !== 1'b1 || obj_type !== 2'd1) begin fails++; $display("FAIL bench_spawn: spawn=%b type=%0d want 1/1", spawn, obj_type); end
    pix(7'd76, 1'b1, 3'd0);
    tests++; if (spawn !== 1'b0) begin fails++; $display("FAIL spawn_pulse: got %b want 0", spawn); end
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL bench_col0_y76: got %b want 011", colour); end
    col_end(0, 31, pre);
    pix(7'd76, 1'b1, 3'd0);
    tests++; if (colour !== 3'b110) begin fails++; $display("FAIL bench_leg_y76: got %b want 110", colour); end
    pix(7'd74, 1'b1, 3'd0);
    tests++; if (colour !== 3'b110) begin fails++; $display("FAIL bench_seat_y74: got %b want 110", colour); end
    pix(7'd70, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL bench_sky_y70: got %b want 011", colour); end
    pix(7'd76, 1'b0, 3'b001);
    tests++; if (colour !== 3'b001) begin fails++; $display("FAIL bench_not_last: got %b want 001", colour); end
    repeat (7) col_end(0, 31, pre);
    pix(7'd77, 1'b1, 3'd0);
    tests++; if (colour !== 3'b110) begin fails++; $display("FAIL bench_leg_col8: got %b want 110", colour); end
    col_end(0, 31, pre);
    pix(7'd77, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL bench_col9_y77: got %b want 011", colour); end
    pix(7'd75, 1'b1, 3'd0);
    tests++; if (colour !== 3'b110 || obj_type !== 2'd1) begin fails++; $display("FAIL bench_col9_seat: colour=%b type=%0d want 110/1", colour, obj_type); end
    col_end(0, 31, pre);
    gap = 4 + int'(pre[7:5]);
    tests++; if (obj_type !== 2'd0) begin fails++; $display("FAIL bench_end: type=%0d want 0", obj_type); end
    bad = 1'b0;
    repeat (gap - 1) begin
      col_end(0, 31, pre);
      if (spawn !== 1'b0 || obj_type !== 2'd0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL gap_length: object began before %0d gap columns", gap); end
    col_end(8, 15, pre);
    tests++; if (obj_type !== 2'd2 || spawn !== 1'b1) begin fails++; $display("FAIL tree_spawn: type=%0d spawn=%b want 2/1 after gap %0d", obj_type, spawn, gap); end
  endtask

  task automatic test_tree();
    logic [31:0] pre;
    pix(7'd65, 1'b1, 3'd0);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL tree_canopy_col0: got %b want 010", colour); end
    pix(7'd75, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL tree_col0_y75: got %b want 011", colour); end
    pix(7'd59, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL tree_above_canopy: got %b want 011", colour); end
    repeat (2) col_end(0, 31, pre);
    pix(7'd75, 1'b1, 3'd0);
    tests++; if (colour !== 3'b100) begin fails++; $display("FAIL tree_trunk_y75: got %b want 100", colour); end
    pix(7'd70, 1'b1, 3'd0);
    tests++; if (colour !== 3'b100) begin fails++; $display("FAIL tree_trunk_top: got %b want 100", colour); end
    pix(7'd69, 1'b1, 3'd0);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL tree_canopy_low: got %b want 010", colour); end
    pix(7'd60, 1'b1, 3'd0);
    tests++; if (colour !== 3'b010) begin fails++; $display("FAIL tree_canopy_top: got %b want 010", colour); end
    col_end(0, 31, pre);
    pix(7'd79, 1'b1, 3'd0);
    tests++; if (colour !== 3'b100) begin fails++; $display("FAIL tree_trunk_col3: got %b want 100", colour); end
    col_end(0, 31, pre);
    pix(7'd79, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL tree_col4_y79: got %b want 011", colour); end
    repeat (2) col_end(0, 31, pre);
    tests++; if (obj_type !== 2'd0 || spawn !== 1'b0) begin fails++; $display("FAIL tree_end: type=%0d spawn=%b want 0/0", obj_type, spawn); end
  endtask

  task automatic test_gap_paths();
    logic [31:0] pre;
    do_reset();
    repeat (3) col_end(0, 31, pre);
    col_end(20, 31, pre);
    tests++; if (obj_type !== 2'd0 || spawn !== 1'b0) begin fails++; $display("FAIL gap_stay: type=%0d spawn=%b want 0/0", obj_type, spawn); end
    repeat (3) col_end(0, 31, pre);
    tests++; if (obj_type !== 2'd0) begin fails++; $display("FAIL min_gap_hold: type=%0d want 0", obj_type); end
    col_end(16, 19, pre);
`ifdef OBJECT_ROCK_EN
    tests++; if (obj_type !== 2'd3 || spawn !== 1'b1) begin fails++; $display("FAIL rock_spawn: type=%0d spawn=%b want 3/1", obj_type, spawn); end
    pix(7'd77, 1'b1, 3'd0);
    tests++; if (colour !== 3'b111) begin fails++; $display("FAIL rock_y77: got %b want 111", colour); end
    pix(7'd79, 1'b1, 3'd0);
    tests++; if (colour !== 3'b111) begin fails++; $display("FAIL rock_y79: got %b want 111", colour); end
    pix(7'd76, 1'b1, 3'd0);
    tests++; if (colour !== 3'b011) begin fails++; $display("FAIL rock_y76: got %b want 011", colour); end
`else
    tests++; if (obj_type !== 2'd0 || spawn !== 1'b0) begin fails++; $display("FAIL rock_range_gap: type=%0d spawn=%b want 0/0", obj_type, spawn); end
    repeat (3) col_end(0, 31, pre);
    col_end(0, 7, pre);
    tests++; if (obj_type !== 2'd1 || spawn !== 1'b1) begin fails++; $display("FAIL bench_after_min_gap: type=%0d spawn=%b want 1/1", obj_type, spawn); end
`endif
  endtask

  task automatic test_golden();
    int bad;
    logic saw_tree;
    bad = 0; saw_tree = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive_step(i);
      g_colour[i] = colour; g_type[i] = obj_type; g_spawn[i] = spawn;
      if (spawn === 1'b1 && obj_type === 2'd2) saw_tree = 1'b1;
      if (y >= 7'd80 && colour !== 3'b010) bad++;
      if (y < 7'd80 && !last_col && colour !== right_colour) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL golden_pixel_select: %0d wrong pixels want 0", bad); end
    tests++; if (!saw_tree) begin fails++; $display("FAIL golden_tree: no tree spawned in %0d steps", N); end
  endtask

  task automatic test_hold();
    int h, bad_hold, bad_resume;
    logic [2:0] c0;
    logic [1:0] t0;
    h = -1;
    for (int i = 300; i < N; i++)
      if (h < 0 && i % 6 == 2 && g_type[i-1] != 2'd0) h = i;
    if (h < 0) h = 302;
    bad_hold = 0; bad_resume = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      if (i == h) begin
        c0 = colour; t0 = obj_type;
        for (int k = 0; k < 50; k++) begin
          enable = 1'b0;
          y = (k % 5 == 0) ? 7'd119 : 7'($urandom_range(119, 0));
          last_col = 1'($urandom_range(1, 0));
          right_colour = 3'($urandom_range(7, 0));
          tick();
          if (colour !== c0 || obj_type !== t0) bad_hold++;
        end
      end
      drive_step(i);
      if (colour !== g_colour[i] || obj_type !== g_type[i] || spawn !== g_spawn[i]) bad_resume++;
    end
    tests++; if (bad_hold != 0) begin fails++; $display("FAIL hold_stable: %0d changed cycles want 0", bad_hold); end
    tests++; if (bad_resume != 0) begin fails++; $display("FAIL hold_resume: %0d mismatched steps want 0", bad_resume); end
  endtask

  task automatic test_reset_replay();
    int s, bad;
    s = -1; bad = 0;
    for (int i = 0; i < N; i++)
      if (s < 0 && g_spawn[i] === 1'b1 && g_type[i] === 2'd2) s = i;
    tests++;
    if (s < 0 || s + 20 >= N) begin
      fails++; $display("FAIL reset_setup: tree spawn index %0d unusable", s);
    end else begin
      do_reset();
      for (int i = 0; i < s + 20; i++) drive_step(i);
      tests++; if (obj_type !== 2'd2) begin fails++; $display("FAIL tree_before_reset: type=%0d want 2", obj_type); end
      resetn = 1'b0; enable = 1'b1; y = 7'd50; last_col = 1'b1;
      tick();
      tests++; if (obj_type !== 2'd0) begin fails++; $display("FAIL midreset_type: got %0d want 0", obj_type); end
      tests++; if (colour !== 3'b011) begin fails++; $display("FAIL midreset_colour: got %b want 011", colour); end
      resetn = 1'b1;
      for (int i = 0; i < N; i++) begin
        drive_step(i);
        if (colour !== g_colour[i] || obj_type !== g_type[i] || spawn !== g_spawn[i]) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL reset_replay: %0d mismatched steps want 0", bad); end
    end
  endtask

  task automatic test_long_run();
    logic saw1, saw2, saw3;
    saw1 = 1'b0; saw2 = 1'b0; saw3 = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      pix(7'(c % 119), 1'b1, 3'd0);
      pix(7'd119, 1'b1, 3'd0);
      if (obj_type === 2'd1) saw1 = 1'b1;
      if (obj_type === 2'd2) saw2 = 1'b1;
      if (obj_type === 2'd3) saw3 = 1'b1;
    end
    tests++; if (!(saw1 && saw2)) begin fails++; $display("FAIL long_run_types: bench=%b tree=%b want 1/1", saw1, saw2); end
`ifdef OBJECT_ROCK_EN
    tests++; if (!saw3) begin fails++; $display("FAIL long_run_rock: got %b want 1", saw3); end
`else
    tests++; if (saw3) begin fails++; $display("FAIL long_run_no_rock: got %b want 0", saw3); end
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_colour_select();
    test_bench();
    test_tree();
    test_gap_paths();
    test_golden();
    test_hold();
    test_reset_replay();
    test_long_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/object_column_gen.md
Name: object_column_gen

Overview:
- Parametrised successor of the scrolling-scene object mapper.
- Produces the colour of each pixel in the newly exposed rightmost column while the playfield scrolls left.
- Walks a gap/object state machine driven by an internal LFSR.
- Supports a configurable screen height, ground line, object set and gap lengths, with per-column shape indexing. Non-rightmost columns take their colour from `right_colour`.

Parameters:
- SCREEN_H, 120, rows per column; the last row is SCREEN_H-1.
- Y_W, 7, width of y.
- GROUND_Y, 80, first ground row; rows >= GROUND_Y are ground.
- COLOUR_W, 3, colour width.
- LFSR_W, 32, LFSR width.
- SEED, 32'hABCB4DA5, LFSR reset value; 0 is replaced by 1.
- MIN_GAP, 4, minimum empty columns between objects.
- INIT_GAP, 4, gap length after reset.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  pixel-step strobe; all state holds when low
- y  in  Y_W  row being drawn this cycle
- last_col  in  1  current pixel lies in the rightmost column
- right_colour  in  COLOUR_W  colour read from memory for the pixel to the right
- colour  out  COLOUR_W  registered pixel colour
- obj_type  out  2  current object type (0 none, 1 bench, 2 tree, 3 rock)
- spawn  out  1  one-cycle pulse when a new object begins

Behaviour:
- Reset (clock edge with resetn=0):
  - colour=3'b011 (sky), obj_type=0, spawn=0.
  - State S_GAP, col_left=INIT_GAP, obj_col=0, LFSR=SEED.
  - Reset mid-column discards the current object.
- Colour latency: colour is registered with 1-cycle latency from the enable/y/last_col/right_colour sample. When enable=0, colour holds.
- Colour select, in priority order:
  1. y >= GROUND_Y -> 3'b010.
  2. !last_col -> right_colour.
  3. Otherwise, shape lookup for (obj_type, obj_col, y).
- Shape lookup, with g=GROUND_Y (sky 3'b011 elsewhere):
  - Bench: width 10. Seat is rows g-6..g-5 across all columns, colour 3'b110. Legs are columns 1 and 8, rows g-4..g-1, colour 3'b110.
  - Tree: width 6. Trunk is columns 2..3, rows g-10..g-1, colour 3'b100. Canopy is all columns, rows g-20..g-11, colour 3'b010.
  - Rock: width 4, rows g-3..g-1, colour 3'b111.
- Column end: enable=1 and y==SCREEN_H-1 and last_col=1. State only advances on this event.
  - If col_left>1: col_left decrements and obj_col increments.
  - If col_left==1: transition, obj_col=0.
- Transitions, with r = LFSR[4:0] sampled on the column-end cycle:
  - S_GAP -> S_OBJ: r<8 gives bench, r<16 gives tree, r<20 gives rock (see Optional Feature). col_left = object width; spawn pulses on the next cycle.
  - S_GAP stays in S_GAP when r>=20; col_left=MIN_GAP.
  - S_OBJ -> S_GAP: col_left = MIN_GAP + LFSR[7:5]; obj_type=0.
- LFSR: Fibonacci, taps LFSR_W, 22, 2, 1 (for 32 bits). Advances only when enable=1. Must never lock at zero.
- col_left width is 5 bits; it never underflows because zero is unreachable.

Optional Feature:
- OBJECT_ROCK_EN.
  - Defined: rock is spawned for 16<=r<20.
  - Undefined: that range stays in S_GAP (obj_type never equals 3); the rock shape logic is not synthesised.

Decomposition:
- Package scene_pkg holds:
  - object type codes and object widths;
  - colour constants SKY, GROUND, WOOD, TRUNK, LEAF, ROCK;
  - shape row offsets.
- Sub-module lfsr_gen (parameters LFSR_W and SEED; ports clock, resetn, enable, q). It replaces the fixed 5-bit-output LFSR.

Test Plan:
- Reset then enable=1, last_col=1, y=10 -> colour=3'b011 after 1 cycle, obj_type=0; y=85 -> 3'b010.
- last_col=0, right_colour=3'b101, y=40 -> colour=3'b101; with y=90 -> 3'b010 (ground overrides).
- Force SEED so r=3 at first column end after 4 columns -> spawn pulse, obj_type=1. Column 1: y=76 -> 3'b110 (leg), y=74 -> 3'b110 (seat), y=70 -> 3'b011.
- Tree spawned (r=12) -> obj_col 2 at y=75 gives 3'b100; obj_col 0 at y=65 gives 3'b010. After 6 columns obj_type=0 and col_left is in 4..11.
- enable=0 for 50 cycles mid-column -> colour, state and LFSR unchanged; resuming continues the identical sequence versus an uninterrupted golden run.
- resetn=0 during tree column 3 -> next cycle obj_type=0 and colour=3'b011; the sequence replays identically from SEED.
- With OBJECT_ROCK_EN undefined, a 10000-column run never yields obj_type==3; with it defined, rock rows g-3..g-1 give 3'b111.
